// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event decoder.
// The auto-repeat build option is BTN_AUTOREPEAT_EN (see button_event_decoder).
package btn_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESSED     = 3'd1,
    ST_LONG_HELD   = 3'd2,
    ST_GAP_WAIT    = 3'd3,
    ST_SECOND_HELD = 3'd4
  } btn_state_e;

  // Defaults assume a 100 MHz clk: 500 ms long press, 250 ms gap, 100 ms repeat.
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned DEF_CNT_W         = 27;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned min_cnt_w(input int unsigned long_c, input int unsigned gap_c,
                                            input int unsigned rep_c);
    return $clog2(max3(long_c, gap_c, rep_c) + 1);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered-history edge detector for a clean, clk-synchronous level.
// No edge is reported on the first sample after reset, so a held input is not seen as a press.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = r_armed & i_level & ~r_prev;
  assign o_fall = r_armed & ~i_level & r_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/long-press pulses.
// Define BTN_AUTOREPEAT_EN to enable repeat_pulse while the button is long-held.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [2:0] S_IDLE        = ST_IDLE;
  localparam logic [2:0] S_PRESSED     = ST_PRESSED;
  localparam logic [2:0] S_LONG_HELD   = ST_LONG_HELD;
  localparam logic [2:0] S_GAP_WAIT    = ST_GAP_WAIT;
  localparam logic [2:0] S_SECOND_HELD = ST_SECOND_HELD;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT =
    CNT_W'(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) - 1);

  logic             w_rise;
  logic             w_fall;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] w_timer_inc;
  logic             w_press;
  logic             w_release;
  logic             w_single;
  logic             w_double;
  logic             w_long;
  logic             w_held;
  logic             r_press;
  logic             r_release;
  logic             r_single;
  logic             r_double;
  logic             r_long;
  logic             r_held;

  btn_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (btn_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // No threshold exceeds TIMER_SAT, so holding there keeps the timer from wrapping.
  assign w_timer_inc = (r_timer == TIMER_SAT) ? r_timer : r_timer + CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic w_repeat;
  logic r_repeat;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_single    = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_repeat    = 1'b0;
`endif
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_PRESSED;
            w_timer_nxt = '0;
            w_press     = 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_fall) begin
            w_state_nxt = S_GAP_WAIT;
            w_timer_nxt = '0;
            w_release   = 1'b1;
          end else if (btn_level) begin
            if (r_timer == LONG_LAST) begin
              w_state_nxt = S_LONG_HELD;
              w_timer_nxt = '0;
              w_long      = 1'b1;
            end else begin
              w_timer_nxt = w_timer_inc;
            end
          end
        end
        S_LONG_HELD: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_release   = 1'b1;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (btn_level) begin
            if (r_timer == REPEAT_LAST) begin
              w_timer_nxt = '0;
              w_repeat    = 1'b1;
            end else begin
              w_timer_nxt = w_timer_inc;
            end
          end
`endif
        end
        S_GAP_WAIT: begin
          // A second press on the expiry cycle still counts as a double click.
          if (w_rise) begin
            w_state_nxt = S_SECOND_HELD;
            w_timer_nxt = '0;
            w_press     = 1'b1;
            w_double    = 1'b1;
          end else if (r_timer == GAP_LAST) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_single    = 1'b1;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
        S_SECOND_HELD: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_release   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign w_held = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_LONG_HELD) ||
                  (w_state_nxt == S_SECOND_HELD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_single  <= w_single;
      r_double  <= w_double;
      r_long    <= w_long;
      r_held    <= w_held;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_repeat <= 1'b0;
    else     r_repeat <= w_repeat;
  end
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign single_click  = r_single;
  assign double_click  = r_double;
  assign long_press    = r_long;
  assign held          = r_held;

endmodule
